// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: robot-side UART command endpoint. Receives 16-bit commands
// as two bytes (high first) and transmits 8-bit response bytes.
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte timeout in WAIT_LO).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   RX / TX         serial in (async, idles high) / serial out (idles high)
//   cmd, cmd_rdy    assembled command and its valid flag
//   clr_cmd_rdy     single-cycle clear of cmd_rdy
//   resp, trmt      response byte and single-cycle send request
//   tx_done         response frame finished, held until next accepted trmt
module uart_cmd_wrapper #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);
    // Preload so the first sample lands BAUD_DIV/2 clocks after the start
    localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV - BAUD_DIV / 2);

    if (BAUD_DIV < 8 || TIMEOUT_BITS < 1) begin : g_param_chk
        $error("uart_cmd_wrapper: BAUD_DIV must be >= 8, TIMEOUT_BITS >= 1");
    end

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    // ---------------- RX bit-level receiver ----------------
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_d;
    logic          r_rx_busy;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_idx;
    logic [7:0]    r_rx_sh;

    logic w_rx_start;
    logic w_rx_tick;
    logic w_rx_done;

    assign w_rx_start = r_rx_d & ~r_rx_s2 & ~r_rx_busy;
    assign w_rx_tick  = r_rx_busy & (r_rx_cnt == C_LAST);
    assign w_rx_done  = w_rx_tick & (r_rx_idx == 4'd9);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_d    <= 1'b1;
            r_rx_busy <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_idx  <= '0;
            r_rx_sh   <= '0;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            if (w_rx_start) begin
                r_rx_busy <= 1'b1;
                r_rx_cnt  <= C_HALF;
                r_rx_idx  <= '0;
            end else if (r_rx_busy) begin
                if (w_rx_tick) begin
                    r_rx_cnt <= '0;
                    if (r_rx_idx == 4'd9) begin
                        r_rx_busy <= 1'b0;
                        r_rx_idx  <= '0;
                    end else begin
                        // start bit falls out the bottom after 9 shifts
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_idx <= r_rx_idx + 4'd1;
                    end
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- command assembly FSM ----------------
    state_t      r_state;
    state_t      w_next;
    logic        w_lat_hi;
    logic        w_set_rdy;
    logic        w_to_hit;
    logic [7:0]  r_hi;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_LIM = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW     = $clog2(TO_LIM + 1);

    logic [TW-1:0] r_to_cnt;

    assign w_to_hit = (r_to_cnt == TW'(TO_LIM));

    // Held at zero outside WAIT_LO, so every entry starts from zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != WAIT_LO || w_rx_start) begin
            r_to_cnt <= '0;
        end else if (!w_to_hit) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    // No timeout: WAIT_LO waits indefinitely for the low byte
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= WAIT_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_lat_hi  = 1'b0;
        w_set_rdy = 1'b0;
        unique case (r_state)
            WAIT_HI: begin
                if (w_rx_done) begin
                    w_lat_hi = 1'b1;
                    w_next   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (w_rx_done) begin
                    w_set_rdy = 1'b1;
                    w_next    = WAIT_HI;
                end else if (w_to_hit) begin
                    w_next = WAIT_HI;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
        end else begin
            if (w_lat_hi) begin
                r_hi <= r_rx_sh;
            end
            // set has priority over either clear source
            if (w_set_rdy) begin
                r_cmd     <= {r_hi, r_rx_sh};
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy ||
                         (w_rx_start && r_state == WAIT_HI)) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

    // ---------------- TX bit-level transmitter ----------------
    logic          r_tx;
    logic          r_tx_busy;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_idx;
    logic [8:0]    r_tx_sh;
    logic          r_tx_done;
    logic          w_tx_tick;

    assign w_tx_tick = r_tx_busy & (r_tx_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx      <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_idx  <= '0;
            r_tx_sh   <= '1;
            r_tx_done <= 1'b0;
        end else if (!r_tx_busy) begin
            if (trmt) begin
                r_tx_busy <= 1'b1;
                r_tx_sh   <= {1'b1, resp};
                r_tx      <= 1'b0;
                r_tx_done <= 1'b0;
                r_tx_cnt  <= '0;
                r_tx_idx  <= '0;
            end
        end else if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b1;
                r_tx      <= 1'b1;
                r_tx_idx  <= '0;
            end else begin
                r_tx     <= r_tx_sh[0];
                r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
                r_tx_idx <= r_tx_idx + 4'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    // Line forced idle while reset is held, without waiting for a clock
    assign TX      = r_tx | ~rst_n;
    assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper: self-checking bench for uart_cmd_wrapper.
// Table-driven command vectors plus hand-written multi-cycle sequences.
module tb_uart_cmd_wrapper;

    localparam int B   = 16;
    localparam int LAT = 3 + B / 2 + 9 * B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    int n_pass = 0;
    int n_tot  = 0;

    uart_cmd_wrapper #(
        .BAUD_DIV    (B),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .trmt       (trmt),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          gap;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[4];

    task automatic chk16(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = fr[i];
            repeat (B - 1) @(negedge clk);
        end
    endtask

    task automatic wait_rdy(input int bound);
        int n;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk1("cmd_rdy_wait", cmd_rdy, 1'b1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        chk1("clr_rdy", cmd_rdy, 1'b0);
    endtask

    // returns 1 time unit after the accepting edge
    task automatic tx_send(input logic [7:0] b);
        @(negedge clk);
        resp = b;
        trmt = 1'b1;
        @(posedge clk);
        #1;
        trmt = 1'b0;
    endtask

    task automatic tx_check(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            chk1("tx_bit_first", TX, fr[i]);
            repeat (B - 1) @(posedge clk);
            #1;
            chk1("tx_bit_last", TX, fr[i]);
            if (i == 9) chk1("tx_done_early", tx_done, 1'b0);
            @(posedge clk);
            #1;
        end
        chk1("tx_done_set", tx_done, 1'b1);
        chk1("tx_idle", TX, 1'b1);
    endtask

    initial begin
        vt[0] = '{hi: 8'hFF, lo: 8'h00, gap: 0,     exp: 16'hFF00};
        vt[1] = '{hi: 8'h00, lo: 8'hFF, gap: 3 * B, exp: 16'h00FF};
        vt[2] = '{hi: 8'hA5, lo: 8'h5A, gap: 1,     exp: 16'hA55A};
        vt[3] = '{hi: 8'h81, lo: 8'h7E, gap: B / 2, exp: 16'h817E};

        rst_n = 1'b0;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp = 8'h00;
        trmt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_tx", TX, 1'b1);
        chk16("rst_cmd", cmd, 16'h0000);
        chk1("rst_rdy", cmd_rdy, 1'b0);
        chk1("rst_tx_done", tx_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (B) @(negedge clk);

        // 0x40, 0x01 with exact cmd_rdy latency from the low start edge
        send_byte(8'h40);
        fork
            send_byte(8'h01);
            begin
                @(negedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1;
                chk1("lat_rdy_before", cmd_rdy, 1'b0);
                @(posedge clk);
                #1;
                chk1("lat_rdy_at", cmd_rdy, 1'b1);
                chk16("lat_cmd", cmd, 16'h4001);
            end
        join
        pulse_clr();
        chk16("cmd_hold_clr", cmd, 16'h4001);

        // table-driven commands
        for (int i = 0; i < 4; i++) begin
            send_byte(vt[i].hi);
            repeat (vt[i].gap) @(negedge clk);
            send_byte(vt[i].lo);
            wait_rdy(4 * B);
            chk16("vec_cmd", cmd, vt[i].exp);
            pulse_clr();
            chk16("vec_cmd_hold", cmd, vt[i].exp);
        end

        // TX 0xA5 with an ignored mid-frame trmt carrying other data
        tx_send(8'hA5);
        fork
            tx_check(8'hA5);
            begin
                repeat (4 * B) @(negedge clk);
                resp = 8'h00;
                trmt = 1'b1;
                @(negedge clk);
                trmt = 1'b0;
            end
        join
        repeat (2 * B) @(posedge clk);
        #1;
        chk1("tx_stays_idle", TX, 1'b1);
        chk1("tx_done_held", tx_done, 1'b1);

        // back-to-back 0x4BF1, 0x5BF2 with no idle bits, no clear
        send_byte(8'h4B);
        send_byte(8'hF1);
        chk1("b2b_rdy1", cmd_rdy, 1'b1);
        chk16("b2b_cmd1", cmd, 16'h4BF1);
        fork
            send_byte(8'h5B);
            begin
                @(negedge clk);
                repeat (2) @(posedge clk);
                #1;
                chk1("b2b_rdy_pre_drop", cmd_rdy, 1'b1);
                @(posedge clk);
                #1;
                chk1("b2b_rdy_drop", cmd_rdy, 1'b0);
                chk16("b2b_cmd_kept", cmd, 16'h4BF1);
            end
        join
        send_byte(8'hF2);
        chk1("b2b_rdy2", cmd_rdy, 1'b1);
        chk16("b2b_cmd2", cmd, 16'h5BF2);
        pulse_clr();

        // full duplex: TX 0xA5 while receiving 0x6022
        fork
            begin
                tx_send(8'hA5);
                tx_check(8'hA5);
            end
            begin
                send_byte(8'h60);
                send_byte(8'h22);
            end
        join
        wait_rdy(4 * B);
        chk16("fdx_cmd", cmd, 16'h6022);

        // reset with a latched high byte, a partial byte and a TX frame
        pulse_clr();
        send_byte(8'h55);
        tx_send(8'h00);
        @(negedge clk);
        RX = 1'b0;
        repeat (4 * B) @(negedge clk);
        chk1("tx_low_pre_rst", TX, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("rst_tx_immediate", TX, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk1("rst_tx_held", TX, 1'b1);
        end
        chk16("mid_rst_cmd", cmd, 16'h0000);
        chk1("mid_rst_rdy", cmd_rdy, 1'b0);
        chk1("mid_rst_tx_done", tx_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        send_byte(8'h47);
        send_byte(8'hF1);
        wait_rdy(4 * B);
        chk16("post_rst_cmd", cmd, 16'h47F1);

        // inter-byte timeout behaviour
        pulse_clr();
        send_byte(8'h43);
        repeat (22 * B) @(negedge clk);
        send_byte(8'h40);
        send_byte(8'h01);
        repeat (B) @(posedge clk);
        #1;
`ifdef CMD_TIMEOUT_EN
        chk16("timeout_cmd", cmd, 16'h4001);
        chk1("timeout_rdy", cmd_rdy, 1'b1);
`else
        chk16("no_timeout_cmd", cmd, 16'h4340);
        chk1("no_timeout_rdy", cmd_rdy, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
